// File: rtl/hms_cnt_if.sv
// Button/tick inputs and time-of-day outputs of the hms_cnt clock counter.
interface hms_cnt_if;
  localparam int unsigned FW = 6;

  logic          i_tick;
  logic          i_mode;
  logic          i_inc;
  logic [FW-1:0] o_sec;
  logic [FW-1:0] o_min;
  logic [FW-1:0] o_hour;
  logic          o_pm;
  logic [1:0]    o_mode;

  modport master (
    output i_tick, i_mode, i_inc,
    input  o_sec, o_min, o_hour, o_pm, o_mode
  );

  modport slave (
    input  i_tick, i_mode, i_inc,
    output o_sec, o_min, o_hour, o_pm, o_mode
  );
endinterface

// File: rtl/hms_cnt.sv
// Hour/minute/second time-of-day counter with MODE/INC manual setting.
// Define HMS_CNT_12H_EN for 12-hour counting (12,1..11) with an AM/PM flag.
module hms_cnt #(
  parameter logic [5:0] SEC_INIT = 6'd0,
  parameter logic [5:0] MIN_INIT = 6'd0
) (
  input  logic      clk,
  input  logic      rst,
  hms_cnt_if.slave  bus
);
  localparam int unsigned FW = 6;
  localparam logic [FW-1:0] SEC_MAX = FW'(59);
  localparam logic [FW-1:0] MIN_MAX = FW'(59);
`ifdef HMS_CNT_12H_EN
  localparam logic [FW-1:0] HOUR_RST = FW'(12);
`else
  localparam logic [FW-1:0] HOUR_RST = FW'(0);
  localparam logic [FW-1:0] HOUR_MAX = FW'(23);
`endif

  typedef enum logic [1:0] {
    CLOCK    = 2'd0,
    SET_SEC  = 2'd1,
    SET_MIN  = 2'd2,
    SET_HOUR = 2'd3
  } mode_e;

  mode_e         mode_q, mode_d;
  logic [FW-1:0] sec_q, sec_d;
  logic [FW-1:0] min_q, min_d;
  logic [FW-1:0] hour_q, hour_d;
  logic          pm_q, pm_d;
  logic          tick_dly_q, tick_dly_d;
  logic          mode_dly_q, mode_dly_d;
  logic          inc_dly_q, inc_dly_d;

  logic          evt_tick, evt_mode, evt_inc;
  logic [FW-1:0] hour_step;
  logic          pm_step;

  function automatic logic [FW-1:0] wrap_inc(input logic [FW-1:0] v,
                                             input logic [FW-1:0] max);
    return (v == max) ? '0 : v + FW'(1);
  endfunction

  // Next hour value shared by the seconds/minutes carry and manual hour setting
  always_comb begin
    hour_step = hour_q;
    pm_step   = pm_q;
`ifdef HMS_CNT_12H_EN
    hour_step = (hour_q == FW'(12)) ? FW'(1) : hour_q + FW'(1);
    pm_step   = (hour_q == FW'(11)) ? ~pm_q : pm_q;
`else
    hour_step = wrap_inc(hour_q, HOUR_MAX);
    pm_step   = 1'b0;
`endif
  end

  always_comb begin
    tick_dly_d = bus.i_tick;
    mode_dly_d = bus.i_mode;
    inc_dly_d  = bus.i_inc;
    evt_tick   = bus.i_tick & ~tick_dly_q;
    evt_mode   = bus.i_mode & ~mode_dly_q;
    evt_inc    = bus.i_inc  & ~inc_dly_q;

    mode_d = mode_q;
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    pm_d   = pm_q;

    // A mode event always wins; the tick or inc seen in the same cycle is dropped
    unique case (mode_q)
      CLOCK: begin
        if (evt_mode) begin
          mode_d = SET_SEC;
        end else if (evt_tick) begin
          sec_d = wrap_inc(sec_q, SEC_MAX);
          if (sec_q == SEC_MAX) begin
            min_d = wrap_inc(min_q, MIN_MAX);
            if (min_q == MIN_MAX) begin
              hour_d = hour_step;
              pm_d   = pm_step;
            end
          end
        end
      end
      SET_SEC: begin
        if (evt_mode)     mode_d = SET_MIN;
        else if (evt_inc) sec_d  = wrap_inc(sec_q, SEC_MAX);
      end
      SET_MIN: begin
        if (evt_mode)     mode_d = SET_HOUR;
        else if (evt_inc) min_d  = wrap_inc(min_q, MIN_MAX);
      end
      SET_HOUR: begin
        if (evt_mode) begin
          mode_d = CLOCK;
        end else if (evt_inc) begin
          hour_d = hour_step;
          pm_d   = pm_step;
        end
      end
      default: mode_d = CLOCK;
    endcase
  end

  // Delay regs reset high so a level already present at reset release is not an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= CLOCK;
      sec_q      <= SEC_INIT;
      min_q      <= MIN_INIT;
      hour_q     <= HOUR_RST;
      pm_q       <= 1'b0;
      tick_dly_q <= 1'b1;
      mode_dly_q <= 1'b1;
      inc_dly_q  <= 1'b1;
    end else begin
      mode_q     <= mode_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      pm_q       <= pm_d;
      tick_dly_q <= tick_dly_d;
      mode_dly_q <= mode_dly_d;
      inc_dly_q  <= inc_dly_d;
    end
  end

  assign bus.o_sec  = sec_q;
  assign bus.o_min  = min_q;
  assign bus.o_hour = hour_q;
  assign bus.o_pm   = pm_q;
  assign bus.o_mode = mode_q;
endmodule
